// File: rtl/raytracer_pkg.sv
// raytracer_pkg: shared types for the ray result path.
//   ray_result_t : one buffered result {pixel_idx, hit, timeout, x, y, z, face_id, steps}
//   FACE_*       : face-id encoding reported by raytracer_top
// Struct field widths are fixed here. Top-level width parameters must match them.
package raytracer_pkg;

    localparam int COORD_W = 16;
    localparam int STEP_W  = 16;
    localparam int PIX_W   = 12;

    localparam logic [2:0] FACE_NONE  = 3'd0;
    localparam logic [2:0] FACE_X_NEG = 3'd1;
    localparam logic [2:0] FACE_X_POS = 3'd2;
    localparam logic [2:0] FACE_Y_NEG = 3'd3;
    localparam logic [2:0] FACE_Y_POS = 3'd4;
    localparam logic [2:0] FACE_Z_NEG = 3'd5;
    localparam logic [2:0] FACE_Z_POS = 3'd6;

    typedef struct packed {
        logic [PIX_W-1:0]   pixel_idx;
        logic               hit;
        logic               timeout;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] z;
        logic [2:0]         face_id;
        logic [STEP_W-1:0]  steps;
    } ray_result_t;

endpackage

// File: rtl/ray_result_collector_fifo.sv
// sync_fifo: single-clock FIFO with a registered output and no fall-through.
//   clk, rst_n   : clock, async active-low reset (empties the FIFO)
//   push, wdata  : write strobe and data (caller guarantees !full || pop)
//   pop, rdata   : read strobe and head entry (rdata valid while !empty)
//   full, empty  : occupancy flags, both derived from registered state
module sync_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  T     wdata,
    input  logic pop,
    output T     rdata,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);

    T           mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, count;

    // Storage is not reset; only pointers define which entries are live.
    // A push while full (with a pop) lands in the slot being vacated this cycle.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/ray_result_collector.sv
// ray_result_collector: buffers raytracer_top results for the host.
//   frame_start                     : clears pixel index, stats, overflow, drop_count
//   ray_done + ray_hit/ray_timeout,
//   hit_voxel_x/y/z, hit_face_id,
//   steps_taken                     : result strobe and fields
//   res_space                       : FIFO not full (host issue-gate)
//   res_valid/res_ready/res_data    : head entry to host
//   frame_done                      : pulse after the result for the last pixel
//   hit/timeout/miss_count          : per-frame saturating stats of pushed results
//   overflow, drop_count            : sticky drop flag and saturating drop count
module ray_result_collector
    import raytracer_pkg::*;
#(
    parameter int COORD_WIDTH      = COORD_W,
    parameter int STEP_COUNT_WIDTH = STEP_W,
    parameter int PIX_BITS         = PIX_W,
    parameter int NUM_PIXELS       = 4096,
    parameter int DEPTH            = 8,
    parameter int STAT_W           = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        frame_start,
    input  logic                        ray_done,
    input  logic                        ray_hit,
    input  logic                        ray_timeout,
    input  logic [COORD_WIDTH-1:0]      hit_voxel_x,
    input  logic [COORD_WIDTH-1:0]      hit_voxel_y,
    input  logic [COORD_WIDTH-1:0]      hit_voxel_z,
    input  logic [2:0]                  hit_face_id,
    input  logic [STEP_COUNT_WIDTH-1:0] steps_taken,
    output logic                        res_space,
    output logic                        res_valid,
    input  logic                        res_ready,
    output ray_result_t                 res_data,
    output logic                        frame_done,
    output logic [STAT_W-1:0]           hit_count,
    output logic [STAT_W-1:0]           timeout_count,
    output logic [STAT_W-1:0]           miss_count,
    output logic                        overflow,
    output logic [STAT_W-1:0]           drop_count
);
    localparam logic [PIX_BITS-1:0] LAST_PIX = PIX_BITS'(NUM_PIXELS - 1);

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + STAT_W'(1);
    endfunction

    logic                full, empty, push, pop, drop;
    logic [PIX_BITS-1:0] pix_idx, cur_idx, nxt_idx;
    logic [STAT_W-1:0]   hit_base, tmo_base, miss_base, drop_base;
    ray_result_t         entry;

    assign pop  = res_valid & res_ready;
    assign push = ray_done & (~full | pop);
    assign drop = ray_done & ~push;

    // frame_start takes effect in its own cycle so a coincident result is pixel 0
    // and the first one counted in the new frame.
    assign cur_idx   = frame_start ? '0 : pix_idx;
    assign nxt_idx   = (cur_idx == LAST_PIX) ? '0 : cur_idx + PIX_BITS'(1);
    assign hit_base  = frame_start ? '0 : hit_count;
    assign tmo_base  = frame_start ? '0 : timeout_count;
    assign miss_base = frame_start ? '0 : miss_count;
    assign drop_base = frame_start ? '0 : drop_count;

    always_comb begin
        entry           = '0;
        entry.pixel_idx = cur_idx;
        entry.hit       = ray_hit;
        entry.timeout   = ray_timeout;
        entry.x         = hit_voxel_x;
        entry.y         = hit_voxel_y;
        entry.z         = hit_voxel_z;
        entry.face_id   = hit_face_id;
        entry.steps     = steps_taken;
    end

    sync_fifo #(.T(ray_result_t), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (entry),
        .pop   (pop),
        .rdata (res_data),
        .full  (full),
        .empty (empty)
    );

    assign res_valid = ~empty;
    assign res_space = ~full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_idx       <= '0;
            frame_done    <= 1'b0;
            hit_count     <= '0;
            timeout_count <= '0;
            miss_count    <= '0;
            overflow      <= 1'b0;
            drop_count    <= '0;
        end else begin
            // Index advances on drops too, keeping it aligned with job order.
            pix_idx    <= ray_done ? nxt_idx : cur_idx;
            frame_done <= ray_done & (cur_idx == LAST_PIX);
            // Only results that reach the FIFO are classified; hit wins over timeout.
            hit_count     <= (push &  ray_hit)                 ? sat_inc(hit_base)  : hit_base;
            timeout_count <= (push & ~ray_hit &  ray_timeout)  ? sat_inc(tmo_base)  : tmo_base;
            miss_count    <= (push & ~ray_hit & ~ray_timeout)  ? sat_inc(miss_base) : miss_base;
            overflow      <= drop | (overflow & ~frame_start);
            drop_count    <= drop ? sat_inc(drop_base) : drop_base;
        end
    end

endmodule

// File: tb/tb_ray_result_collector.sv
// tb_ray_result_collector: directed bench. u_dut uses NUM_PIXELS=4096, u_dut4 uses
// NUM_PIXELS=4 for frame wrap; both share all inputs.
module tb_ray_result_collector;
    import raytracer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_start, ray_done, ray_hit, ray_timeout, res_ready;
    logic [15:0] vx, vy, vz, steps;
    logic [2:0]  face;

    logic        res_space, res_valid, frame_done, overflow;
    ray_result_t res_data;
    logic [15:0] hit_count, timeout_count, miss_count, drop_count;

    logic        res_space4, res_valid4, frame_done4, overflow4;
    ray_result_t res_data4;
    logic [15:0] hit_count4, timeout_count4, miss_count4, drop_count4;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ray_result_collector u_dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .ray_done(ray_done),
        .ray_hit(ray_hit), .ray_timeout(ray_timeout),
        .hit_voxel_x(vx), .hit_voxel_y(vy), .hit_voxel_z(vz),
        .hit_face_id(face), .steps_taken(steps),
        .res_space(res_space), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .frame_done(frame_done),
        .hit_count(hit_count), .timeout_count(timeout_count), .miss_count(miss_count),
        .overflow(overflow), .drop_count(drop_count)
    );

    ray_result_collector #(.NUM_PIXELS(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .ray_done(ray_done),
        .ray_hit(ray_hit), .ray_timeout(ray_timeout),
        .hit_voxel_x(vx), .hit_voxel_y(vy), .hit_voxel_z(vz),
        .hit_face_id(face), .steps_taken(steps),
        .res_space(res_space4), .res_valid(res_valid4), .res_ready(res_ready),
        .res_data(res_data4), .frame_done(frame_done4),
        .hit_count(hit_count4), .timeout_count(timeout_count4), .miss_count(miss_count4),
        .overflow(overflow4), .drop_count(drop_count4)
    );

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic ray_result_t mk(input int idx, input logic h, input logic t,
                                       input int x, input int y, input int z,
                                       input int f, input int s);
        ray_result_t r;
        r.pixel_idx = 12'(idx);
        r.hit       = h;
        r.timeout   = t;
        r.x         = 16'(x);
        r.y         = 16'(y);
        r.z         = 16'(z);
        r.face_id   = 3'(f);
        r.steps     = 16'(s);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One result strobe lasting one cycle; ray_done returns low afterwards.
    task automatic send(input logic h, input logic t, input int x, input int f, input int s);
        ray_done = 1'b1; ray_hit = h; ray_timeout = t;
        vx = 16'(x); vy = 16'(x + 1); vz = 16'(x + 2); face = 3'(f); steps = 16'(s);
        step();
        ray_done = 1'b0; ray_hit = 1'b0; ray_timeout = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_start = 0; ray_done = 0; ray_hit = 0; ray_timeout = 0; res_ready = 0;
        vx = 0; vy = 0; vz = 0; face = 0; steps = 0;
        rst_n = 1'b0;
        repeat (2) step();
        // Reset state
        chk("rst_space",   res_space, 1);
        chk("rst_valid",   res_valid, 0);
        chk("rst_hits",    hit_count, 0);
        chk("rst_tmo",     timeout_count, 0);
        chk("rst_miss",    miss_count, 0);
        chk("rst_ovf",     overflow, 0);
        chk("rst_drops",   drop_count, 0);
        chk("rst_fdone",   frame_done, 0);
        rst_n = 1'b1;
        step();

        // 1: single hit, visible one cycle later
        ray_done = 1; ray_hit = 1; ray_timeout = 0;
        vx = 3; vy = 4; vz = 5; face = FACE_X_POS; steps = 7;
        #1;
        chk("t1_no_fallthru", res_valid, 0);
        step();
        ray_done = 0; ray_hit = 0;
        chk("t1_valid", res_valid, 1);
        chk("t1_data",  res_data, mk(0, 1, 0, 3, 4, 5, 2, 7));
        chk("t1_hits",  hit_count, 1);

        // drain, then restart the frame so indices begin at 0
        res_ready = 1; step(); res_ready = 0;
        chk("t1_empty", res_valid, 0);
        frame_start = 1; step(); frame_start = 0;
        chk("t1_fs_hits", hit_count, 0);

        // 2: fill 8, drop the 9th
        for (int i = 0; i < 9; i++) begin
            send(0, 0, i, 0, i);
            if (i == 6) chk("t2_space7", res_space, 1);
            if (i == 7) begin
                chk("t2_space8", res_space, 0);
                chk("t2_ovf8",   overflow, 0);
            end
        end
        chk("t2_ovf",   overflow, 1);
        chk("t2_drops", drop_count, 1);
        chk("t2_miss",  miss_count, 8);
        chk("t2_head",  res_data.pixel_idx, 0);

        // 3: push + pop while full: no drop, entry gets index 9
        ray_done = 1; res_ready = 1; vx = 99; #1;
        chk("t3_head_before", res_data.pixel_idx, 0);
        step();
        ray_done = 0; res_ready = 0;
        chk("t3_space",  res_space, 0);
        chk("t3_drops",  drop_count, 1);
        chk("t3_head",   res_data.pixel_idx, 1);
        res_ready = 1;
        for (int k = 1; k <= 8; k++) begin
            chk("t3_drain_idx", res_data.pixel_idx, (k == 8) ? 9 : k);
            step();
        end
        chk("t3_empty", res_valid, 0);
        chk("t3_space_back", res_space, 1);
        res_ready = 0;

        // 4: NUM_PIXELS=4 frame wrap
        do_reset();
        send(1, 0, 10, FACE_Y_NEG, 1); chk("t4_fd0", frame_done4, 0);
        send(0, 1, 20, FACE_NONE, 2);  chk("t4_fd1", frame_done4, 0);
        send(0, 0, 30, FACE_NONE, 3);  chk("t4_fd2", frame_done4, 0);
        send(1, 1, 40, FACE_Z_POS, 4); chk("t4_fd3", frame_done4, 1);
        chk("t4_hits", hit_count4, 2);
        chk("t4_tmo",  timeout_count4, 1);
        chk("t4_miss", miss_count4, 1);
        chk("t4_ovf",  overflow4, 0);
        chk("t4_drop", drop_count4, 0);
        chk("t4_space", res_space4, 1);
        send(0, 0, 50, FACE_NONE, 5);  chk("t4_fd_once", frame_done4, 0);
        res_ready = 1;
        for (int k = 0; k < 5; k++) begin
            if (k == 3) chk("t4_e3", res_data4, mk(3, 1, 1, 40, 41, 42, 6, 4));
            chk("t4_idx", res_data4.pixel_idx, (k == 4) ? 0 : k);
            chk("t4_valid", res_valid4, 1);
            step();
        end
        chk("t4_empty", res_valid4, 0);
        res_ready = 0;

        // 5: frame_start coincident with ray_done (u_dut index now 5)
        for (int i = 0; i < 9; i++) send(0, 0, i, 0, 0);
        chk("t5_ovf_set", overflow, 1);
        res_ready = 1; repeat (8) step(); res_ready = 0;
        chk("t5_drained", res_valid, 0);
        for (int i = 0; i < 3; i++) send(1, 0, i, 1, 0);
        frame_start = 1;
        send(0, 1, 77, FACE_Z_NEG, 9);
        frame_start = 0;
        chk("t5_hits", hit_count, 0);
        chk("t5_tmo",  timeout_count, 1);
        chk("t5_miss", miss_count, 0);
        chk("t5_ovf",  overflow, 0);
        chk("t5_drop", drop_count, 0);
        res_ready = 1;
        for (int k = 0; k < 3; k++) begin
            chk("t5_old_idx", res_data.pixel_idx, 14 + k);
            step();
        end
        chk("t5_new_entry", res_data, mk(0, 0, 1, 77, 78, 79, 5, 9));
        step();
        res_ready = 0;

        // 6: async reset with entries queued
        for (int i = 0; i < 3; i++) send(1, 0, i, 0, 0);
        chk("t6_queued", res_valid, 1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", res_valid, 0);
        chk("t6_async_space", res_space, 1);
        chk("t6_async_hits",  hit_count, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();
        chk("t6_empty_after", res_valid, 0);
        send(0, 0, 5, 0, 0);
        chk("t6_idx0", res_data.pixel_idx, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
